// File: rtl/m_ifetch_ctrl_if.sv
// m_ifetch_ctrl_if: instruction memory read request/acknowledge bus
interface m_ifetch_ctrl_if;
  logic        mem_req;
  logic [29:0] mem_adr;
  logic        mem_ack;
  logic [31:0] mem_dat;
  modport master (output mem_req, mem_adr, input mem_ack, mem_dat);
  modport slave (input mem_req, mem_adr, output mem_ack, mem_dat);
endinterface

// File: rtl/m_ifetch_ctrl.sv
// m_ifetch_ctrl: prefetching instruction fetch sequencer feeding the operation register
module m_ifetch_ctrl #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  corerunning,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  input  logic                  instr_done,
  m_ifetch_ctrl_if.master       mem,
  output logic                  opreg_load,
  output logic [31:0]           opreg_di,
  output logic                  instr_valid,
  output logic [31:0]           fetch_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_KILL = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fa_q, fa_d;
  logic [29:0]   radr_q, radr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d, cnt_after;
  logic          valid_q, valid_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   adr_mem_q [DEPTH];
  logic [31:0]   dat_mem_q [DEPTH];
  logic          push, start;

  assign push        = (state_q == S_REQ) & mem.mem_ack & ~redirect;
  assign opreg_load  = corerunning & ~redirect & (cnt_q != '0) & (~valid_q | instr_done);
  assign opreg_di    = dat_mem_q[rd_ptr_q];
  assign cnt_after   = cnt_q + (AW+1)'(push) - (AW+1)'(opreg_load);
  assign mem.mem_req = state_q != S_IDLE;
  assign mem.mem_adr = (state_q == S_IDLE) ? fa_q[31:2] : radr_q;
  assign instr_valid = valid_q;
  assign fetch_pc    = fpc_q;

  // request sequencing: only one read outstanding, a redirected read is drained in KILL
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = (corerunning & ~redirect & (cnt_q < FULL)) ? S_REQ : S_IDLE;
      S_REQ:   state_d = ~mem.mem_ack ? (redirect ? S_KILL : S_REQ)
                       : (~redirect & corerunning & (cnt_after < FULL)) ? S_REQ : S_IDLE;
      S_KILL:  state_d = mem.mem_ack ? S_IDLE : S_KILL;
      default: state_d = S_IDLE;
    endcase
  end

  // fetch address, latched request address, FIFO pointers and operation register tracking
  always_comb begin
    start    = (state_d == S_REQ) & ((state_q != S_REQ) | mem.mem_ack);
    fa_d     = redirect ? (redirect_pc & ~32'h3) : push ? fa_q + 32'd4 : fa_q;
    radr_d   = start ? fa_d[31:2] : radr_q;
    cnt_d    = redirect ? '0 : cnt_after;
    rd_ptr_d = redirect ? '0 : rd_ptr_q + AW'(opreg_load);
    wr_ptr_d = redirect ? '0 : wr_ptr_q + AW'(push);
    valid_d  = redirect ? 1'b0 : opreg_load ? 1'b1 : (instr_done & (cnt_q == '0)) ? 1'b0 : valid_q;
    fpc_d    = opreg_load ? adr_mem_q[rd_ptr_q] : fpc_q;
  end

  // control state with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      fa_q     <= RESET_PC;
      radr_q   <= RESET_PC[31:2];
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      valid_q  <= 1'b0;
      fpc_q    <= RESET_PC;
    end else begin
      state_q  <= state_d;
      fa_q     <= fa_d;
      radr_q   <= radr_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      valid_q  <= valid_d;
      fpc_q    <= fpc_d;
    end
  end

  // prefetch storage needs no reset: entries are only read when counted valid
  always_ff @(posedge clk) begin
    if (push) begin
      adr_mem_q[wr_ptr_q] <= fa_q;
      dat_mem_q[wr_ptr_q] <= mem.mem_dat;
    end
  end
endmodule
